// File: rtl/seq_scan_pkg.sv
// Shared types, default widths and the pattern-length mask helper for the scan controller.
package seq_scan_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int PAT_W_MAX_DEF = 8;
  localparam int CNT_W_DEF     = 16;
  localparam int LEN_W_DEF     = $clog2(PAT_W_MAX_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // Low 'len' bits set; len is expected already clamped to PAT_W_MAX_DEF.
  function automatic logic [PAT_W_MAX_DEF-1:0] len_mask(input logic [LEN_W_DEF-1:0] len);
    logic [PAT_W_MAX_DEF-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W_MAX_DEF; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word handshake between the producer and the scan controller.
// Ready is a registered state decode on the slave side, so there is no valid->ready path.
interface seq_scan_ctrl_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/seq_det_core.sv
// Programmable bit-serial Mealy detector: match is combinational on the presented bit.
// History and bits-seen persist until clr_i, so patterns may straddle word boundaries.
module seq_det_core
  import seq_scan_pkg::*;
#(
  parameter  int PAT_W_MAX = PAT_W_MAX_DEF,
  localparam int LEN_W     = $clog2(PAT_W_MAX + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 bit_vld_i,
  input  logic                 bit_i,
  input  logic [PAT_W_MAX-1:0] pat_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 match_o
);

  logic [PAT_W_MAX-2:0] hist;
  logic [LEN_W-1:0]     seen;
  logic [LEN_W-1:0]     seen_incl;
  logic [PAT_W_MAX-1:0] window;
  logic [PAT_W_MAX-1:0] mask;

  // seen_incl counts the bit being presented, so a len-bit pattern can complete on its len-th bit.
  always_comb begin
    window    = {hist, bit_i};
    mask      = len_mask(len_i);
    seen_incl = (seen == LEN_W'(PAT_W_MAX)) ? seen : seen + 1'b1;
    match_o   = bit_vld_i && (len_i != '0) && (seen_incl >= len_i) &&
                ((window & mask) == (pat_i & mask));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist <= '0;
      seen <= '0;
    end else if (clr_i) begin
      hist <= '0;
      seen <= '0;
    end else if (bit_vld_i) begin
      hist <= window[PAT_W_MAX-2:0];
      seen <= seen_incl;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serialises handshaked words MSB-first into seq_det_core, counts matches, raises a sticky irq.
// One word per DATA_W+1 cycles; ready is low while shifting and in IDLE.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int PAT_W_MAX = PAT_W_MAX_DEF,
  parameter  int CNT_W     = CNT_W_DEF,
  localparam int LEN_W     = $clog2(PAT_W_MAX + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [PAT_W_MAX-1:0] cfg_pat_i,
  input  logic [LEN_W-1:0]     cfg_len_i,
  input  logic [CNT_W-1:0]     cfg_thresh_i,
  seq_scan_ctrl_if.slave       s,
  output logic                 busy_o,
  output logic                 match_o,
  output logic [CNT_W-1:0]     match_cnt_o,
  output logic                 irq_o,
  input  logic                 irq_clr_i
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e               state;
  logic [DATA_W-1:0]    shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic [PAT_W_MAX-1:0] pat_q;
  logic [LEN_W-1:0]     len_q;
  logic [CNT_W-1:0]     thresh_q;
  logic                 ready_q;

  logic                 start_fire;
  logic                 bit_vld;
  logic                 core_match;
  logic                 irq_set;
  logic [LEN_W-1:0]     len_clamped;

  assign s.ready     = ready_q;
  assign start_fire  = (state == IDLE) && start_i && !stop_i;
  assign bit_vld     = (state == SHIFT);
  assign len_clamped = (cfg_len_i > LEN_W'(PAT_W_MAX)) ? LEN_W'(PAT_W_MAX) : cfg_len_i;

  // A saturated counter can never newly equal the threshold, so irq cannot re-fire there.
  assign irq_set = core_match && (match_cnt_o != '1) && (thresh_q != '0) &&
                   ((match_cnt_o + 1'b1) == thresh_q);

  seq_det_core #(
    .PAT_W_MAX (PAT_W_MAX)
  ) u_core (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (start_fire),
    .bit_vld_i (bit_vld),
    .bit_i     (shreg[DATA_W-1]),
    .pat_i     (pat_q),
    .len_i     (len_q),
    .match_o   (core_match)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      thresh_q    <= '0;
      ready_q     <= 1'b0;
      busy_o      <= 1'b0;
      match_o     <= 1'b0;
      match_cnt_o <= '0;
      irq_o       <= 1'b0;
    end else begin
      match_o <= core_match;
      if (core_match && (match_cnt_o != '1)) begin
        match_cnt_o <= match_cnt_o + 1'b1;
      end
      if (irq_set) begin
        irq_o <= 1'b1;
      end else if (irq_clr_i) begin
        irq_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_fire) begin
            pat_q       <= cfg_pat_i;
            len_q       <= len_clamped;
            thresh_q    <= cfg_thresh_i;
            match_cnt_o <= '0;
            irq_o       <= 1'b0;
            state       <= WAIT;
            ready_q     <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        WAIT: begin
          if (stop_i) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            busy_o  <= 1'b0;
          end else if (s.valid) begin
            shreg   <= s.data;
            bit_idx <= '0;
            state   <= SHIFT;
            ready_q <= 1'b0;
          end
        end
        SHIFT: begin
          // Any match on the bit presented this cycle is already counted above, even on stop.
          if (stop_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
              state   <= WAIT;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
